zone_pump_arbiter: RTL

ZONE_PUMP_ARBITER -- requirements
Module: zone_pump_arbiter

---
 rtl/zone_pump_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/zone_pump_arbiter.sv
// -----------------------------------------------------------------------------
// zone_pump_arbiter
// Shares one irrigation pump between up to four zones. A round-robin arbiter
// grants one valve at a time. A grant ends when the owner releases its request,
// when inhibit is raised, or after MAX_RUN cycles. Every grant is followed by a
// fixed dead time of GAP cycles before the next arbitration.
//
// Ports
//   clk           : clock, all state updates on the rising edge
//   rst_n         : asynchronous active-low reset
//   req           : per-zone water request (level, held while demand persists)
//   inhibit       : rain/maintenance lockout; blocks new grants, aborts a run
//   grant         : registered valve enables, one-hot or zero
//   grant_id      : registered index of the granted zone, held while idle
//   pump_on       : registered, high exactly when grant is nonzero
//   timeout_pulse : one-cycle pulse in the first GAP cycle after a MAX_RUN cut
//   busy          : high whenever the FSM is in RUN or GAP
// -----------------------------------------------------------------------------
module zone_pump_arbiter #(
    parameter int unsigned NUM_ZONES = 4,
    parameter int unsigned MAX_RUN   = 200,
    parameter int unsigned GAP       = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_ZONES-1:0] req,
    input  logic                 inhibit,
    output logic [NUM_ZONES-1:0] grant,
    output logic [1:0]           grant_id,
    output logic                 pump_on,
    output logic                 timeout_pulse,
    output logic                 busy
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned GAP_W = 4;
    localparam int unsigned ID_W  = 2;
    localparam int unsigned REQ_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    state_e               state_q;
    logic [NUM_ZONES-1:0] grant_q;
    logic [ID_W-1:0]      grant_id_q;
    logic [ID_W-1:0]      last_q;
    logic [CNT_W-1:0]     run_cnt_q;
    logic [GAP_W-1:0]     gap_cnt_q;
    logic                 pump_q;
    logic                 timeout_q;
    logic                 busy_q;

    // Arbitration signals (combinational, consumed only by the register block)
    logic [REQ_W-1:0] req_ext;
    logic [REQ_W-1:0] onehot_d;
    logic [ID_W-1:0]  winner_d;
    logic [ID_W:0]    cand;
    logic             found_d;
    logic             own_req;
    logic             run_done;

    // Round-robin search starting one past the most recently granted zone.
    // req is zero-extended so non-existent zones can never win.
    always_comb begin
        req_ext  = REQ_W'(req);
        winner_d = last_q;
        found_d  = 1'b0;
        cand     = '0;
        for (int unsigned k = 1; k <= NUM_ZONES; k++) begin
            cand = {1'b0, last_q} + (ID_W + 1)'(k);
            if (cand >= (ID_W + 1)'(NUM_ZONES)) begin
                cand = cand - (ID_W + 1)'(NUM_ZONES);
            end
            if (!found_d && req_ext[ID_W'(cand)]) begin
                found_d  = 1'b1;
                winner_d = ID_W'(cand);
            end
        end
        onehot_d = REQ_W'(1) << winner_d;
        own_req  = req_ext[grant_id_q];
        run_done = (run_cnt_q == CNT_W'(MAX_RUN));
    end

    // Arbiter FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            last_q     <= ID_W'(NUM_ZONES - 1);
            run_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            pump_q     <= 1'b0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!inhibit && found_d) begin
                        state_q    <= ST_RUN;
                        grant_q    <= NUM_ZONES'(onehot_d);
                        grant_id_q <= winner_d;
                        last_q     <= winner_d;
                        pump_q     <= 1'b1;
                        busy_q     <= 1'b1;
                        run_cnt_q  <= CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    // Release, inhibit and timeout collapse into one exit; the
                    // pulse flags only a genuine MAX_RUN cut.
                    if (!own_req || inhibit || run_done) begin
                        state_q   <= ST_GAP;
                        grant_q   <= '0;
                        pump_q    <= 1'b0;
                        timeout_q <= own_req && !inhibit && run_done;
                        gap_cnt_q <= GAP_W'(1);
                    end else begin
                        run_cnt_q <= run_cnt_q + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    // Dead time is fixed; requests and inhibit are ignored here
                    if (gap_cnt_q == GAP_W'(GAP)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                    pump_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign grant         = grant_q;
    assign grant_id      = grant_id_q;
    assign pump_on       = pump_q;
    assign timeout_pulse = timeout_q;
    assign busy          = busy_q;

endmodule
